// File: rtl/core_mem_arbiter_pkg.sv
// Shared encodings for the core memory arbiter: requester ownership and
// arbiter FSM states, plus a small saturating-increment helper.
package core_common;

    localparam logic ARB_OWNER_DATA  = 1'b0;
    localparam logic ARB_OWNER_INSTR = 1'b1;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RSP  = 2'd2;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_mux.sv
// Owner-select mux for the bus request fields; fetch never writes, and an
// idle bus drives all-zero fields.
module core_mem_arbiter_mux
    import core_common::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              bus_en,
    input  logic              sel_owner,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_wen,
    input  logic [STRB_W-1:0] dmem_strb,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_strb,
    output logic [DATA_W-1:0] mem_wdata
);

    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        if (bus_en) begin
            if (sel_owner == ARB_OWNER_INSTR) begin
                mem_addr = imem_addr;
            end else begin
                mem_addr  = dmem_addr;
                mem_wen   = dmem_wen;
                mem_strb  = dmem_strb;
                mem_wdata = dmem_wdata;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between fetch and LSU: one outstanding transaction,
// data has priority, and a starvation counter eventually lets fetch win.
module core_mem_arbiter
    import core_common::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STRB_W       = DATA_W / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_gnt,
    output logic              imem_err,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              dmem_req,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_wen,
    input  logic [STRB_W-1:0] dmem_strb,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_gnt,
    output logic              dmem_err,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_strb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rsp_valid,
    input  logic              mem_rsp_err,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;
    logic [3:0] starve_cnt;
    logic       any_req;
    logic       sel_owner;
    logic       cur_owner;
    logic       handshake;
    logic       rsp_fire;

    assign any_req = imem_req | dmem_req;

    // Fetch only overrides data once data has won LIMIT times in a row while fetch waited.
    always_comb begin
        sel_owner = ARB_OWNER_DATA;
        if (dmem_req && !(imem_req && (starve_cnt == LIMIT))) begin
            sel_owner = ARB_OWNER_DATA;
        end else if (imem_req) begin
            sel_owner = ARB_OWNER_INSTR;
        end
    end

    assign cur_owner = (state == ARB_IDLE) ? sel_owner : owner;
    assign mem_req   = g_resetn && (((state == ARB_IDLE) && any_req) || (state == ARB_REQ));
    assign handshake = mem_req && mem_gnt;

    core_mem_arbiter_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_mux (
        .bus_en     (mem_req),
        .sel_owner  (cur_owner),
        .imem_addr  (imem_addr),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (handshake) begin
                    state_nxt = ARB_RSP;
                end else if (any_req) begin
                    state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    state_nxt = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (mem_rsp_valid) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= ARB_IDLE;
            owner      <= ARB_OWNER_DATA;
            starve_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if ((state == ARB_IDLE) && any_req) begin
                owner <= sel_owner;
            end
            if (handshake) begin
                if ((cur_owner == ARB_OWNER_DATA) && imem_req) begin
                    starve_cnt <= sat_inc4(starve_cnt, LIMIT);
                end else begin
                    starve_cnt <= 4'd0;
                end
            end
        end
    end

    // Responses are only honoured while waiting for one; stale ones after reset fall on the floor.
    assign rsp_fire   = (state == ARB_RSP) && mem_rsp_valid;
    assign imem_gnt   = rsp_fire && (owner == ARB_OWNER_INSTR);
    assign dmem_gnt   = rsp_fire && (owner == ARB_OWNER_DATA);
    assign imem_err   = imem_gnt && mem_rsp_err;
    assign dmem_err   = dmem_gnt && mem_rsp_err;
    assign imem_rdata = (state == ARB_RSP) ? mem_rsp_rdata : '0;
    assign dmem_rdata = (state == ARB_RSP) ? mem_rsp_rdata : '0;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: requester and bus models feed the DUT,
// expected bus transactions and responses are queued and checked by a monitor.
module tb_core_mem_arbiter;
    import core_common::*;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } bus_t;

    typedef struct {
        logic        instr;
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        imem_req = 1'b0;
    logic [63:0] imem_addr = '0;
    logic        imem_gnt, imem_err;
    logic [63:0] imem_rdata;
    logic        dmem_req = 1'b0;
    logic [63:0] dmem_addr = '0;
    logic        dmem_wen = 1'b0;
    logic [7:0]  dmem_strb = '0;
    logic [63:0] dmem_wdata = '0;
    logic        dmem_gnt, dmem_err;
    logic [63:0] dmem_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic        mem_rsp_err = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [63:0] imem_q[$];
    bus_t        dmem_q[$];
    rsp_t        bus_rsp_q[$];
    bus_t        exp_bus_q[$];
    rsp_t        exp_rsp_q[$];

    int   imem_delay = 0;
    int   gnt_wait = 0;
    int   rsp_lat = 1;
    int   gwait_cnt = 0;
    int   rsp_cnt = 0;
    logic bus_busy = 1'b0;
    logic imem_gnt_s = 1'b0;
    logic dmem_gnt_s = 1'b0;

    core_mem_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .STRB_W       (8),
        .STARVE_LIMIT (4)
    ) dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_err      (imem_err),
        .imem_rdata    (imem_rdata),
        .dmem_req      (dmem_req),
        .dmem_addr     (dmem_addr),
        .dmem_wen      (dmem_wen),
        .dmem_strb     (dmem_strb),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_err      (dmem_err),
        .dmem_rdata    (dmem_rdata),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_strb      (mem_strb),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_err   (mem_rsp_err),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] actual);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got %h with nothing expected", name, actual);
    endtask

    // One clock of the requester and bus models, each acting a little after the edge.
    task automatic cycle();
        @(posedge g_clk);
        #1;
        if (imem_gnt_s && imem_q.size() > 0) void'(imem_q.pop_front());
        if (dmem_gnt_s && dmem_q.size() > 0) void'(dmem_q.pop_front());
        imem_req  = (imem_delay == 0) && (imem_q.size() > 0);
        imem_addr = imem_req ? imem_q[0] : 64'd0;
        if (imem_delay > 0) imem_delay--;
        dmem_req = dmem_q.size() > 0;
        if (dmem_req) begin
            dmem_addr  = dmem_q[0].addr;
            dmem_wen   = dmem_q[0].wen;
            dmem_strb  = dmem_q[0].strb;
            dmem_wdata = dmem_q[0].wdata;
        end else begin
            dmem_addr  = '0;
            dmem_wen   = 1'b0;
            dmem_strb  = '0;
            dmem_wdata = '0;
        end
        #1;
        mem_gnt       = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_rdata = '0;
        if (bus_busy) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus_busy      = 1'b0;
                mem_rsp_valid = 1'b1;
                if (bus_rsp_q.size() > 0) begin
                    mem_rsp_err   = bus_rsp_q[0].err;
                    mem_rsp_rdata = bus_rsp_q[0].rdata;
                    void'(bus_rsp_q.pop_front());
                end
            end
        end else if (mem_req) begin
            if (gwait_cnt == gnt_wait) begin
                mem_gnt   = 1'b1;
                bus_busy  = 1'b1;
                rsp_cnt   = rsp_lat;
                gwait_cnt = 0;
            end else begin
                gwait_cnt++;
            end
        end
        #1;
        imem_gnt_s = imem_gnt;
        dmem_gnt_s = dmem_gnt;
    endtask

    task automatic applyStimulus(input logic is_instr, input bus_t req, input logic err, input logic [63:0] rdata);
        rsp_t r;
        r.instr = is_instr;
        r.err   = err;
        r.rdata = rdata;
        if (is_instr) imem_q.push_back(req.addr);
        else dmem_q.push_back(req);
    endtask

    task automatic expectTxn(input logic is_instr, input bus_t req, input logic err, input logic [63:0] rdata);
        bus_t b;
        rsp_t r;
        b = req;
        if (is_instr) begin
            b.wen   = 1'b0;
            b.strb  = '0;
            b.wdata = '0;
        end
        r.instr = is_instr;
        r.err   = err;
        r.rdata = rdata;
        exp_bus_q.push_back(b);
        exp_rsp_q.push_back(r);
        r.instr = 1'b0;
        bus_rsp_q.push_back(r);
    endtask

    function automatic bus_t mk(input logic [63:0] addr, input logic wen, input logic [7:0] strb, input logic [63:0] wdata);
        bus_t b;
        b.addr  = addr;
        b.wen   = wen;
        b.strb  = strb;
        b.wdata = wdata;
        return b;
    endfunction

    task automatic waitDone(input string name);
        int budget = 300;
        while ((exp_bus_q.size() > 0 || exp_rsp_q.size() > 0 || imem_q.size() > 0 || dmem_q.size() > 0) && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_timeout: got %0d pending expected 0", name, exp_bus_q.size() + exp_rsp_q.size());
        end
        repeat (3) cycle();
    endtask

    // Scoreboard monitor: checks bus fields every cycle a request is presented and every response pulse.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (mem_req) begin
                if (exp_bus_q.size() == 0) begin
                    reportUnexpected("unexpected_mem_req", mem_addr);
                end else begin
                    checkOutput("bus_addr", mem_addr, exp_bus_q[0].addr);
                    checkOutput("bus_wen_strb", {55'd0, mem_wen, mem_strb}, {55'd0, exp_bus_q[0].wen, exp_bus_q[0].strb});
                    checkOutput("bus_wdata", mem_wdata, exp_bus_q[0].wdata);
                    if (mem_gnt) void'(exp_bus_q.pop_front());
                end
            end
            if (imem_gnt || dmem_gnt) begin
                if (exp_rsp_q.size() == 0) begin
                    reportUnexpected("unexpected_gnt", {62'd0, imem_gnt, dmem_gnt});
                end else begin
                    rsp_t e;
                    e = exp_rsp_q.pop_front();
                    checkOutput("rsp_port", {62'd0, imem_gnt, dmem_gnt}, e.instr ? 64'd2 : 64'd1);
                    checkOutput("rsp_err", {62'd0, imem_err, dmem_err}, e.instr ? {62'd0, e.err, 1'b0} : {63'd0, e.err});
                    checkOutput("rsp_rdata", e.instr ? imem_rdata : dmem_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        imem_req  = 1'b1;
        imem_addr = 64'h1234;
        dmem_req  = 1'b1;
        dmem_addr = 64'h5678;
        #12;
        checkOutput("reset_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("reset_mem_addr", mem_addr, 64'd0);
        checkOutput("reset_gnts", {62'd0, imem_gnt, dmem_gnt}, 64'd0);
        imem_req  = 1'b0;
        imem_addr = '0;
        dmem_req  = 1'b0;
        dmem_addr = '0;
        #10;
        g_resetn = 1'b1;
        repeat (2) cycle();

        $display("[TB] fetch only");
        gnt_wait = 0;
        rsp_lat  = 1;
        expectTxn(1'b1, mk(64'h1000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hDEADBEEF);
        applyStimulus(1'b1, mk(64'h1000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hDEADBEEF);
        waitDone("fetch_only");

        $display("[TB] simultaneous fetch and store");
        expectTxn(1'b0, mk(64'h80, 1'b1, 8'hFF, 64'h55), 1'b0, 64'h0);
        expectTxn(1'b1, mk(64'h2000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hCAFE);
        applyStimulus(1'b1, mk(64'h2000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hCAFE);
        applyStimulus(1'b0, mk(64'h80, 1'b1, 8'hFF, 64'h55), 1'b0, 64'h0);
        waitDone("simultaneous");

        $display("[TB] starvation guard");
        for (int i = 0; i < 4; i++) expectTxn(1'b0, mk(64'h100 + 64'(i * 8), 1'b0, 8'h00, 64'h0), 1'b0, 64'hA0 + 64'(i));
        expectTxn(1'b1, mk(64'h3000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hF00D);
        for (int i = 4; i < 6; i++) expectTxn(1'b0, mk(64'h100 + 64'(i * 8), 1'b0, 8'h00, 64'h0), 1'b0, 64'hA0 + 64'(i));
        applyStimulus(1'b1, mk(64'h3000, 1'b0, 8'h00, 64'h0), 1'b0, 64'hF00D);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, mk(64'h100 + 64'(i * 8), 1'b0, 8'h00, 64'h0), 1'b0, 64'hA0 + 64'(i));
        waitDone("starvation");
        checkOutput("starve_cnt_cleared", {60'd0, dut.starve_cnt}, 64'd0);

        $display("[TB] owner lock during stall");
        gnt_wait   = 3;
        imem_delay = 1;
        expectTxn(1'b0, mk(64'h400, 1'b0, 8'h00, 64'h0), 1'b0, 64'h1111);
        expectTxn(1'b1, mk(64'h4000, 1'b0, 8'h00, 64'h0), 1'b0, 64'h2222);
        applyStimulus(1'b0, mk(64'h400, 1'b0, 8'h00, 64'h0), 1'b0, 64'h1111);
        applyStimulus(1'b1, mk(64'h4000, 1'b0, 8'h00, 64'h0), 1'b0, 64'h2222);
        waitDone("lock");
        gnt_wait = 0;

        $display("[TB] error response");
        rsp_lat = 2;
        expectTxn(1'b0, mk(64'h500, 1'b0, 8'h00, 64'h0), 1'b1, 64'hBAD0);
        applyStimulus(1'b0, mk(64'h500, 1'b0, 8'h00, 64'h0), 1'b1, 64'hBAD0);
        waitDone("error");

        $display("[TB] reset while awaiting response");
        rsp_lat = 6;
        begin
            rsp_t r;
            r.instr = 1'b0;
            r.err   = 1'b0;
            r.rdata = 64'h6666;
            exp_bus_q.push_back(mk(64'h600, 1'b0, 8'h00, 64'h0));
            bus_rsp_q.push_back(r);
        end
        applyStimulus(1'b0, mk(64'h600, 1'b0, 8'h00, 64'h0), 1'b0, 64'h6666);
        repeat (3) cycle();
        checkOutput("pre_reset_state", {62'd0, dut.state}, {62'd0, ARB_RSP});
        #1;
        g_resetn = 1'b0;
        #1;
        checkOutput("in_reset_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("in_reset_state", {62'd0, dut.state}, {62'd0, ARB_IDLE});
        dmem_q.delete();
        repeat (2) cycle();
        g_resetn = 1'b1;
        repeat (6) cycle();
        checkOutput("post_reset_state", {62'd0, dut.state}, {62'd0, ARB_IDLE});
        checkOutput("post_reset_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("pending_expectations", 64'(exp_bus_q.size() + exp_rsp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
